// File: rtl/scene_renderer.sv
// VGA 640x480@60 scene renderer: sync generation, per-frame input snapshot and
// a prioritised ball/paddle/block/border colour mux, all outputs one pixel late.
module scene_renderer #(
   parameter int PIX_DIV    = 2,
   parameter int BLOCK_COLS = 12,
   parameter int BLOCK_ROWS = 6,
   parameter int BLOCK_LEFT = 32,
   parameter int BLOCK_W    = 48,
   parameter int BLOCK_TOP  = 48,
   parameter int BLOCK_H    = 16,
   parameter int PADDLE_Y   = 448,
   parameter int PADDLE_W   = 64,
   parameter int PADDLE_H   = 8,
   parameter int BALL_SIZE  = 8
) (
   input  logic                               CLK,
   input  logic                               RESET_N,
   input  logic [9:0]                         PADDLE_X_PIXEL,
   input  logic [9:0]                         BALL_X_PIXEL,
   input  logic [9:0]                         BALL_Y_PIXEL,
   input  logic [BLOCK_COLS*BLOCK_ROWS-1:0]   BLOCK_STATE,
   output logic                               FRAME_RENDERED,
   output logic                               VGA_HSYNC,
   output logic                               VGA_VSYNC,
   output logic [7:0]                         VGA_RGB
);

   localparam int H_VIS    = 640;
   localparam int H_SYNC_S = 656;
   localparam int H_SYNC_E = 752;
   localparam int H_TOT    = 800;
   localparam int V_VIS    = 480;
   localparam int V_SYNC_S = 490;
   localparam int V_SYNC_E = 492;
   localparam int V_TOT    = 525;
   localparam int NBLK     = BLOCK_COLS * BLOCK_ROWS;
   localparam int GRID_R   = BLOCK_LEFT + BLOCK_COLS * BLOCK_W;
   localparam int GRID_B   = BLOCK_TOP + BLOCK_ROWS * BLOCK_H;
   localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int XOW      = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
   localparam int YOW      = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
   localparam int IW       = (NBLK > 1) ? $clog2(NBLK) : 1;

   logic [DW-1:0]   div;
   logic            pe;
   logic [9:0]      h, v, h_nx, v_nx;
   logic            h_last, v_last;
   logic [9:0]      col, row;
   logic [XOW-1:0]  xo;
   logic [YOW-1:0]  yo;
   logic [9:0]      px_s, bx_s, by_s;
   logic [NBLK-1:0] blk_s;
   logic [10:0]     x, y;
   logic            in_ball, in_paddle, in_grid, in_border, blk_on, visible;
   logic [IW-1:0]   idx;
   logic [7:0]      row_colour, colour;

   assign pe     = (div == DW'(PIX_DIV - 1));
   assign h_last = (h == 10'(H_TOT - 1));
   assign v_last = (v == 10'(V_TOT - 1));
   assign h_nx   = h_last ? '0 : h + 10'd1;
   assign v_nx   = v_last ? '0 : v + 10'd1;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)  div <= '0;
      else if (pe)   div <= '0;
      else           div <= div + DW'(1);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         h <= '0;
         v <= '0;
      end else if (pe) begin
         h <= h_nx;
         if (h_last) v <= v_nx;
      end
   end

   // Cell counters are re-seeded one pixel before the grid edge so that col/xo
   // and row/yo always describe the (h,v) currently held in the counters.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         col <= '0;
         xo  <= '0;
         row <= '0;
         yo  <= '0;
      end else if (pe) begin
         if (h_nx == 10'(BLOCK_LEFT)) begin
            col <= '0;
            xo  <= '0;
         end else if (xo == XOW'(BLOCK_W - 1)) begin
            col <= col + 10'd1;
            xo  <= '0;
         end else begin
            xo  <= xo + XOW'(1);
         end
         if (h_last) begin
            if (v_nx == 10'(BLOCK_TOP)) begin
               row <= '0;
               yo  <= '0;
            end else if (yo == YOW'(BLOCK_H - 1)) begin
               row <= row + 10'd1;
               yo  <= '0;
            end else begin
               yo  <= yo + YOW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         px_s  <= '0;
         bx_s  <= '0;
         by_s  <= '0;
         blk_s <= '0;
      end else if (pe && h_last && v_last) begin
         px_s  <= PADDLE_X_PIXEL;
         bx_s  <= BALL_X_PIXEL;
         by_s  <= BALL_Y_PIXEL;
         blk_s <= BLOCK_STATE;
      end
   end

   always_comb begin
      x         = {1'b0, h};
      y         = {1'b0, v};
      visible   = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
      in_ball   = (x >= {1'b0, bx_s}) && (x < {1'b0, bx_s} + 11'(BALL_SIZE)) &&
                  (y >= {1'b0, by_s}) && (y < {1'b0, by_s} + 11'(BALL_SIZE));
      in_paddle = (x >= {1'b0, px_s}) && (x < {1'b0, px_s} + 11'(PADDLE_W)) &&
                  (y >= 11'(PADDLE_Y)) && (y < 11'(PADDLE_Y + PADDLE_H));
      in_grid   = (x >= 11'(BLOCK_LEFT)) && (x < 11'(GRID_R)) &&
                  (y >= 11'(BLOCK_TOP)) && (y < 11'(GRID_B));
      in_border = (x < 11'd8) || (x >= 11'(H_VIS - 8)) || (y < 11'd8);
      idx       = IW'(int'(row) * BLOCK_COLS + int'(col));
      blk_on    = in_grid && blk_s[idx] && (xo != '0) && (yo != '0);
      case (row)
         10'd0:   row_colour = 8'hE0;
         10'd1:   row_colour = 8'hEC;
         10'd2:   row_colour = 8'hFC;
         10'd3:   row_colour = 8'h1C;
         10'd4:   row_colour = 8'h03;
         10'd5:   row_colour = 8'hE3;
         default: row_colour = 8'h00;
      endcase
      colour = 8'h00;
      if (in_ball)        colour = 8'hFF;
      else if (in_paddle) colour = 8'h1F;
      else if (blk_on)    colour = row_colour;
      else if (in_border) colour = 8'h92;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         VGA_HSYNC      <= 1'b1;
         VGA_VSYNC      <= 1'b1;
         VGA_RGB        <= '0;
         FRAME_RENDERED <= 1'b0;
      end else begin
         FRAME_RENDERED <= pe && (h == 10'(H_VIS - 1)) && (v == 10'(V_VIS - 1));
         if (pe) begin
            VGA_HSYNC <= !((h >= 10'(H_SYNC_S)) && (h < 10'(H_SYNC_E)));
            VGA_VSYNC <= !((v >= 10'(V_SYNC_S)) && (v < 10'(V_SYNC_E)));
            VGA_RGB   <= visible ? colour : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_scene_renderer.sv
// Scoreboard bench for scene_renderer: per-pixel expected values from a geometric
// model, folded into per-line signatures, plus fixed pixel probes and timing checks.
module tb_scene_renderer;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [9:0]  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
   logic [71:0] BLOCK_STATE;
   logic        FRAME_RENDERED, VGA_HSYNC, VGA_VSYNC;
   logic [7:0]  VGA_RGB;

   scene_renderer dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .PADDLE_X_PIXEL (PADDLE_X_PIXEL),
      .BALL_X_PIXEL   (BALL_X_PIXEL),
      .BALL_Y_PIXEL   (BALL_Y_PIXEL),
      .BLOCK_STATE    (BLOCK_STATE),
      .FRAME_RENDERED (FRAME_RENDERED),
      .VGA_HSYNC      (VGA_HSYNC),
      .VGA_VSYNC      (VGA_VSYNC),
      .VGA_RGB        (VGA_RGB)
   );

   always #10 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int         f;
      int         x;
      int         y;
      logic [7:0] c;
      string      tag;
   } pt_t;
   pt_t pts[$];

   task automatic add_pt(input int f, input int x, input int y, input logic [7:0] c, input string tag);
      pt_t p;
      p.f = f; p.x = x; p.y = y; p.c = c; p.tag = tag;
      pts.push_back(p);
   endtask

   logic [7:0]  row_tbl [6] = '{8'hE0, 8'hEC, 8'hFC, 8'h1C, 8'h03, 8'hE3};
   logic [9:0]  s_px, s_bx, s_by;
   logic [71:0] s_blk;

   function automatic logic [9:0] model_pix(input int x, input int y);
      logic       hs, vs;
      logic [7:0] c;
      int         col, row, xo, yo;
      hs = !(x >= 656 && x < 752);
      vs = !(y >= 490 && y < 492);
      c  = 8'h00;
      if (x < 640 && y < 480) begin
         if (x >= int'(s_bx) && x < int'(s_bx) + 8 && y >= int'(s_by) && y < int'(s_by) + 8)
            c = 8'hFF;
         else if (x >= int'(s_px) && x < int'(s_px) + 64 && y >= 448 && y < 456)
            c = 8'h1F;
         else begin
            if (x >= 32 && x < 608 && y >= 48 && y < 144) begin
               col = (x - 32) / 48; xo = (x - 32) % 48;
               row = (y - 48) / 16; yo = (y - 48) % 16;
               if (s_blk[row*12 + col] && xo != 0 && yo != 0) c = row_tbl[row];
            end
            if (c == 8'h00 && (x < 8 || x >= 632 || y < 8)) c = 8'h92;
         end
      end
      return {hs, vs, c};
   endfunction

   // free-running negedge monitor for sync / frame pulse timing
   int cyc = 0;
   bit sync_en = 0;
   int fr_cyc[$];
   int fr_run = 0, fr_wmax = 0;
   int hs_run = 0, hs_fall = -1, hs_low_min = 32'h7fffffff, hs_low_max = 0, hs_per_min = 32'h7fffffff, hs_per_max = 0;
   int vs_run = 0, vs_fall = -1, vs_low_min = 32'h7fffffff, vs_low_max = 0, vs_per_min = 32'h7fffffff, vs_per_max = 0;
   logic p_fr = 0, p_hs = 1, p_vs = 1;

   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         if (FRAME_RENDERED === 1'b1) begin
            if (!p_fr) fr_cyc.push_back(cyc);
            fr_run++;
         end else begin
            if (p_fr && fr_run > fr_wmax) fr_wmax = fr_run;
            fr_run = 0;
         end
         if (sync_en) begin
            if (!VGA_HSYNC) hs_run++;
            if (p_hs && !VGA_HSYNC) begin
               if (hs_fall >= 0) begin
                  if (cyc - hs_fall < hs_per_min) hs_per_min = cyc - hs_fall;
                  if (cyc - hs_fall > hs_per_max) hs_per_max = cyc - hs_fall;
               end
               hs_fall = cyc;
            end
            if (!p_hs && VGA_HSYNC) begin
               if (hs_run < hs_low_min) hs_low_min = hs_run;
               if (hs_run > hs_low_max) hs_low_max = hs_run;
               hs_run = 0;
            end
            if (!VGA_VSYNC) vs_run++;
            if (p_vs && !VGA_VSYNC) begin
               if (vs_fall >= 0) begin
                  if (cyc - vs_fall < vs_per_min) vs_per_min = cyc - vs_fall;
                  if (cyc - vs_fall > vs_per_max) vs_per_max = cyc - vs_fall;
               end
               vs_fall = cyc;
            end
            if (!p_vs && VGA_VSYNC) begin
               if (vs_run < vs_low_min) vs_low_min = vs_run;
               if (vs_run > vs_low_max) vs_low_max = vs_run;
               vs_run = 0;
            end
         end
         p_fr = FRAME_RENDERED;
         p_hs = VGA_HSYNC;
         p_vs = VGA_VSYNC;
      end
   end

   logic [9:0]  exp_q[$];
   logic [31:0] oh = 0, eh = 0;
   int mh = 0, mv = 0, frm = 0;

   task automatic step_pixel();
      logic [9:0] o, e;
      @(posedge CLK);
      @(posedge CLK);
      exp_q.push_back(model_pix(mh, mv));
      if (mh == 799 && mv == 524) begin
         s_px = PADDLE_X_PIXEL; s_bx = BALL_X_PIXEL; s_by = BALL_Y_PIXEL; s_blk = BLOCK_STATE;
      end
      #1;
      o  = {VGA_HSYNC, VGA_VSYNC, VGA_RGB};
      e  = exp_q.pop_front();
      oh = (oh * 33) ^ 32'(o);
      eh = (eh * 33) ^ 32'(e);
      foreach (pts[i])
         if (pts[i].f == frm && pts[i].x == mh && pts[i].y == mv)
            check(pts[i].tag, 32'(VGA_RGB), 32'(pts[i].c));
      if (mh == 799) begin
         check($sformatf("f%0d_line%0d", frm, mv), oh, eh);
         oh = 0;
         eh = 0;
      end
      if (frm == 0 && mv == 10 && mh == 0) begin
         BALL_X_PIXEL   = 10'd100;
         BALL_Y_PIXEL   = 10'd200;
         PADDLE_X_PIXEL = 10'd300;
         BLOCK_STATE    = '1;
         BLOCK_STATE[13] = 1'b0;
      end
      if (frm == 1 && mv == 150 && mh == 0) begin
         BALL_X_PIXEL   = 10'd400;
         PADDLE_X_PIXEL = 10'd620;
      end
      if (mh == 799) begin
         mh = 0;
         if (mv == 524) begin
            mv = 0;
            frm++;
         end else mv++;
      end else mh++;
   endtask

   int rel1, rel2;

   initial begin
      add_pt(0,   3,   3, 8'hFF, "ball_at_origin");
      add_pt(0,   8,   7, 8'h92, "top_border");
      add_pt(0,  60,  60, 8'h00, "no_blocks_yet");
      add_pt(0, 639, 100, 8'h92, "right_border");
      add_pt(1, 103, 204, 8'hFF, "ball_hit");
      add_pt(1, 100, 200, 8'hFF, "ball_corner");
      add_pt(1, 108, 204, 8'h00, "ball_right_edge");
      add_pt(1, 300, 450, 8'h1F, "paddle_left");
      add_pt(1, 299, 450, 8'h00, "paddle_outside");
      add_pt(1, 700, 100, 8'h00, "hblank");
      add_pt(1,  90,  70, 8'h00, "cleared_block");
      add_pt(1,  60,  70, 8'hEC, "block_r1c0");
      add_pt(1, 130,  70, 8'hEC, "block_r1c2");
      add_pt(1,  80,  70, 8'h00, "gap_col");
      add_pt(1,  90,  64, 8'h00, "gap_row");
      add_pt(1,  90,  55, 8'hE0, "block_r0c1");
      add_pt(1,  33,  49, 8'hE0, "grid_corner");
      add_pt(1, 403, 204, 8'h00, "ball_not_moved_yet");
      add_pt(2, 403, 204, 8'hFF, "ball_moved");
      add_pt(2, 103, 204, 8'h00, "ball_old_pos");
      add_pt(2, 625, 450, 8'h1F, "paddle_clip");
      add_pt(2, 639, 455, 8'h1F, "paddle_last_px");
      add_pt(2,   0, 450, 8'h92, "paddle_no_wrap");
      add_pt(2, 640, 450, 8'h00, "paddle_blank");
      add_pt(2,   0, 300, 8'h92, "pre_reset_border");
      add_pt(3,   3,   3, 8'hFF, "ball_after_reset");
      add_pt(3, 300, 450, 8'h00, "paddle_reset_snap");

      RESET_N = 1'b0;
      PADDLE_X_PIXEL = '0; BALL_X_PIXEL = '0; BALL_Y_PIXEL = '0; BLOCK_STATE = '0;
      s_px = '0; s_bx = '0; s_by = '0; s_blk = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_hsync", 32'(VGA_HSYNC), 32'd1);
      check("rst_vsync", 32'(VGA_VSYNC), 32'd1);
      check("rst_rgb",   32'(VGA_RGB),   32'd0);
      check("rst_frame", 32'(FRAME_RENDERED), 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      rel1 = cyc;
      sync_en = 1;

      while (!(frm == 2 && mv == 300 && mh == 1)) step_pixel();

      sync_en = 0;
      check("hsync_low_min", 32'(hs_low_min), 32'd192);
      check("hsync_low_max", 32'(hs_low_max), 32'd192);
      check("hsync_per_min", 32'(hs_per_min), 32'd1600);
      check("hsync_per_max", 32'(hs_per_max), 32'd1600);
      check("vsync_low_min", 32'(vs_low_min), 32'd3200);
      check("vsync_low_max", 32'(vs_low_max), 32'd3200);
      check("vsync_period",  32'(vs_per_min), 32'd840000);
      check("frame_count",   32'(fr_cyc.size()), 32'd2);
      if (fr_cyc.size() >= 2) begin
         check("frame_first", 32'(fr_cyc[0] - rel1), 32'd767680);
         check("frame_period", 32'(fr_cyc[1] - fr_cyc[0]), 32'd840000);
      end

      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      check("midrst_hsync", 32'(VGA_HSYNC), 32'd1);
      check("midrst_vsync", 32'(VGA_VSYNC), 32'd1);
      check("midrst_rgb",   32'(VGA_RGB),   32'd0);
      check("midrst_frame", 32'(FRAME_RENDERED), 32'd0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      rel2 = cyc;
      exp_q.delete();
      oh = 0; eh = 0;
      mh = 0; mv = 0; frm = 3;
      s_px = '0; s_bx = '0; s_by = '0; s_blk = '0;

      for (int i = 0; i < 420000; i++) step_pixel();

      check("frame_count_after_rst", 32'(fr_cyc.size()), 32'd3);
      if (fr_cyc.size() >= 3)
         check("frame_after_rst", 32'(fr_cyc[2] - rel2), 32'd767680);
      check("frame_width", 32'(fr_wmax), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
